branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Dynamic branch direction predictor for the 5-stage RISC-V core.
- Produces `predict_en_D` for the conditional branch in D. The datapath pipes it to E as `predict_en_E` for misprediction/flush logic.
- Trains on the resolved outcome (`branch_h_E`) of the branch in E.
- Uses a gshare pattern-history table (PHT) of 2-bit saturating counters plus a global history register (GHR), with misprediction performance counters.

Parameters:
- IDX_W, 6, PHT index width; PHT holds 2^IDX_W entries.
- GHR_W, 6, global history length; must satisfy GHR_W <= IDX_W. 0 gives a pure PC-indexed bimodal predictor.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pc_D  in  32  PC of the instruction in D.
- branch_D  in  1  instruction in D is a conditional branch.
- predict_en_D  out  1  1 = predict taken. Valid only when branch_D = 1; 0 otherwise.
- pht_idx_D  out  IDX_W  PHT index used for this prediction; the datapath pipes it to E.
- branch_E  in  1  instruction in E is a conditional branch (bubbles deliver 0).
- branch_h_E  in  1  resolved outcome in E, 1 = taken.
- predict_en_E  in  1  prediction that was made for the branch now in E.
- pht_idx_E  in  IDX_W  piped index for the branch now in E.
- stall_E  in  1  E is held this cycle; training is suppressed.
- br_cnt  out  CNT_W  number of branches resolved since reset.
- mis_cnt  out  CNT_W  number of mispredictions since reset.

Behaviour:
- Index: `pht_idx_D = pc_D[IDX_W+1:2] XOR {zero-extend(GHR)}`.
  - pc[1:0] is ignored.
  - The GHR is aligned to the LSBs and XORed into the low GHR_W bits.
- Lookup is combinational from registered state; there is no read latency.
  - `predict_en_D = branch_D & PHT[pht_idx_D][1]`.
- Training strobe: `train = branch_E & ~stall_E`. All state changes happen on the rising clk edge in which train = 1; nothing else modifies state.
- Counter update: `PHT[pht_idx_E]` increments if branch_h_E = 1, else decrements.
  - Saturates at 2'b11 and 2'b00; no wrap-around.
- GHR update: `GHR <= {GHR[GHR_W-2:0], branch_h_E}`, newest outcome in the LSB.
  - The GHR is non-speculative; it is updated only from resolved outcomes.
  - When GHR_W = 0, no GHR exists and the index is the PC bits only.
- Performance counters:
  - `br_cnt` increments on every train.
  - `mis_cnt` increments on train when `predict_en_E != branch_h_E`.
  - Both are free-running and wrap modulo 2^CNT_W.
- Simultaneous D lookup and E update to the same index: D sees the pre-update value (no bypass). The same applies to the GHR: D uses the old GHR in the cycle of a train.
- The D-stage stall (loadstall) needs no input. The lookup is stateless, so a held instruction in D re-reads the same (or freshly trained) entry.
- A D→E flush needs no input. A flushed instruction enters E as a bubble with branch_E = 0 and causes no training.
- Reset (asynchronous, any time including mid-training):
  - all PHT entries go to 2'b01 (weakly not-taken);
  - GHR = 0;
  - br_cnt = mis_cnt = 0;
  - predict_en_D therefore reads 0.
  - The first edge after rst_n deasserts can train normally.
- The PHT is implemented in flops so that reset clears it; an inferred RAM is not used.

Test Plan:
- Reset: assert rst_n = 0 mid-run, then release → predict_en_D = 0 for any pc_D with branch_D = 1; br_cnt = mis_cnt = 0.
- Saturation (GHR_W = 0): train pc 0x100 taken 3× → predict_en_D flips to 1 after the first train (01→10). After 3 trains, one not-taken → 10, still predicts taken. Then not-taken ×5 → 00, and one taken → 01, predict 0.
- Gshare aliasing: with GHR = 6'b000011, pc_D = 0x10C gives pht_idx_D = 0x03 ^ 0x03 = 0. Verify that pc_D = 0x100 with GHR = 0 maps to the same index 0.
- Stall gating: branch_E = 1 with stall_E = 1 for 3 cycles, then stall_E = 0 → exactly one PHT/GHR update; br_cnt advances by 1.
- Same-cycle read/write: pht_idx_D == pht_idx_E, entry = 01, train taken → predict_en_D = 0 in that cycle and 1 in the next.
- Counters: 10 branches with predict_en_E != branch_h_E on 4 of them → br_cnt = 10, mis_cnt = 4. With CNT_W = 4, 17 trains → br_cnt = 1.

Source files
------------

// File: rtl/branch_predictor.sv
// Gshare branch direction predictor: PHT of 2-bit saturating counters indexed by PC ^ global history.
// Lookup is combinational (zero latency); training and history/perf-counter updates land on the clock edge.
// No backpressure: a held E stage (stall_E) simply suppresses training for that cycle.
module branch_predictor #(
  parameter int IDX_W = 6,
  parameter int GHR_W = 6,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      pc_D,
  input  logic             branch_D,
  output logic             predict_en_D,
  output logic [IDX_W-1:0] pht_idx_D,
  input  logic             branch_E,
  input  logic             branch_h_E,
  input  logic             predict_en_E,
  input  logic [IDX_W-1:0] pht_idx_E,
  input  logic             stall_E,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mis_cnt
);

  localparam int ENTRIES = 1 << IDX_W;

  // Flop-based table so that reset can bring every entry to weakly not-taken.
  logic [1:0]       pht [ENTRIES];
  logic [IDX_W-1:0] ghr_ext;
  logic [IDX_W-1:0] idx_d;
  logic             train;
  logic             unused_pc;

  // Only resolved, non-stalled branches train; bubbles arrive with branch_E = 0.
  assign train = branch_E & ~stall_E;

  // Word-aligned PC bits hashed with the history (history sits in the low bits).
  assign idx_d        = pc_D[IDX_W+1:2] ^ ghr_ext;
  assign pht_idx_D    = idx_d;
  assign predict_en_D = branch_D & pht[idx_d][1];

  // Byte-offset and high PC bits do not participate in the index.
  assign unused_pc = ^{pc_D[31:IDX_W+2], pc_D[1:0]};

  generate
    if (GHR_W > 0) begin : g_ghr
      logic [GHR_W-1:0] ghr;

      // Non-speculative history: shift in the resolved outcome, newest in the LSB.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ghr <= '0;
        end else if (train) begin
          ghr <= (ghr << 1) | GHR_W'(branch_h_E);
        end
      end

      assign ghr_ext = IDX_W'(ghr);
    end else begin : g_no_ghr
      // Pure bimodal: index comes from PC bits only.
      assign ghr_ext = '0;
    end
  endgenerate

  // Saturating counter update of the entry the E-stage branch was predicted from.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        pht[i] <= 2'b01;
      end
    end else if (train) begin
      if (branch_h_E && (pht[pht_idx_E] != 2'b11)) begin
        pht[pht_idx_E] <= pht[pht_idx_E] + 2'b01;
      end else if (!branch_h_E && (pht[pht_idx_E] != 2'b00)) begin
        pht[pht_idx_E] <= pht[pht_idx_E] - 2'b01;
      end
    end
  end

  // Free-running performance counters; they wrap naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt  <= '0;
      mis_cnt <= '0;
    end else if (train) begin
      br_cnt <= br_cnt + CNT_W'(1);
      if (predict_en_E != branch_h_E) begin
        mis_cnt <= mis_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_D;
  logic        branch_D;
  logic        branch_E;
  logic        branch_h_E;
  logic        predict_en_E;
  logic [5:0]  pht_idx_E;
  logic        stall_E;

  // Gshare instance (defaults) and bimodal instance with narrow counters, sharing stimulus.
  logic        pred_a;
  logic [5:0]  idx_a;
  logic [31:0] br_a;
  logic [31:0] mis_a;
  logic        pred_b;
  logic [5:0]  idx_b;
  logic [3:0]  br_b;
  logic [3:0]  mis_b;

  int n_cmp;
  int n_fail;

  branch_predictor u_dut (
    .clk(clk), .rst_n(rst_n), .pc_D(pc_D), .branch_D(branch_D),
    .predict_en_D(pred_a), .pht_idx_D(idx_a),
    .branch_E(branch_E), .branch_h_E(branch_h_E), .predict_en_E(predict_en_E),
    .pht_idx_E(pht_idx_E), .stall_E(stall_E),
    .br_cnt(br_a), .mis_cnt(mis_a)
  );

  branch_predictor #(.IDX_W(6), .GHR_W(0), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .pc_D(pc_D), .branch_D(branch_D),
    .predict_en_D(pred_b), .pht_idx_D(idx_b),
    .branch_E(branch_E), .branch_h_E(branch_h_E), .predict_en_E(predict_en_E),
    .pht_idx_E(pht_idx_E), .stall_E(stall_E),
    .br_cnt(br_b), .mis_cnt(mis_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pc(input logic [31:0] pc);
    pc_D     = pc;
    branch_D = 1'b1;
    #1;
  endtask

  task automatic do_train(input logic [5:0] idx, input logic h, input logic p);
    branch_E     = 1'b1;
    stall_E      = 1'b0;
    pht_idx_E    = idx;
    branch_h_E   = h;
    predict_en_E = p;
    step();
    branch_E     = 1'b0;
    branch_h_E   = 1'b0;
    predict_en_E = 1'b0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    set_pc(32'h100);
    n_cmp++; if (pred_a !== 1'b0) begin n_fail++; $display("FAIL rst_pred_a: got %0d want 0", pred_a); end
    n_cmp++; if (br_a !== 32'd0) begin n_fail++; $display("FAIL rst_br: got %0d want 0", br_a); end
    n_cmp++; if (mis_a !== 32'd0) begin n_fail++; $display("FAIL rst_mis: got %0d want 0", mis_a); end
    // Build up some state, then reset while a train is being presented.
    do_train(6'd0, 1'b1, 1'b0);
    do_train(6'd0, 1'b1, 1'b0);
    n_cmp++; if (pred_b !== 1'b1) begin n_fail++; $display("FAIL pre_rst_pred_b: got %0d want 1", pred_b); end
    branch_E   = 1'b1;
    branch_h_E = 1'b1;
    pht_idx_E  = 6'd0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (br_a !== 32'd0) begin n_fail++; $display("FAIL async_rst_br: got %0d want 0", br_a); end
    #9;
    branch_E   = 1'b0;
    branch_h_E = 1'b0;
    rst_n      = 1'b1;
    #1;
    n_cmp++; if (pred_b !== 1'b0) begin n_fail++; $display("FAIL post_rst_pred_b: got %0d want 0", pred_b); end
    n_cmp++; if (pred_a !== 1'b0) begin n_fail++; $display("FAIL post_rst_pred_a: got %0d want 0", pred_a); end
    n_cmp++; if (mis_a !== 32'd0) begin n_fail++; $display("FAIL post_rst_mis: got %0d want 0", mis_a); end
    step();
    do_train(6'd0, 1'b1, 1'b0);
    n_cmp++; if (br_a !== 32'd1) begin n_fail++; $display("FAIL first_train_br: got %0d want 1", br_a); end
    n_cmp++; if (pred_b !== 1'b1) begin n_fail++; $display("FAIL first_train_pred_b: got %0d want 1", pred_b); end
  endtask

  task automatic test_saturation();
    reset_dut();
    set_pc(32'h100);
    n_cmp++; if (idx_b !== 6'd0) begin n_fail++; $display("FAIL sat_idx: got %0h want 0", idx_b); end
    n_cmp++; if (pred_b !== 1'b0) begin n_fail++; $display("FAIL sat_init: got %0d want 0", pred_b); end
    do_train(6'd0, 1'b1, 1'b0);
    n_cmp++; if (pred_b !== 1'b1) begin n_fail++; $display("FAIL sat_t1: got %0d want 1", pred_b); end
    do_train(6'd0, 1'b1, 1'b1);
    do_train(6'd0, 1'b1, 1'b1);
    do_train(6'd0, 1'b0, 1'b1);
    n_cmp++; if (pred_b !== 1'b1) begin n_fail++; $display("FAIL sat_hi_nt1: got %0d want 1", pred_b); end
    do_train(6'd0, 1'b0, 1'b1);
    n_cmp++; if (pred_b !== 1'b0) begin n_fail++; $display("FAIL sat_nt2: got %0d want 0", pred_b); end
    for (int i = 0; i < 4; i++) do_train(6'd0, 1'b0, 1'b0);
    do_train(6'd0, 1'b1, 1'b0);
    n_cmp++; if (pred_b !== 1'b0) begin n_fail++; $display("FAIL sat_lo_t1: got %0d want 0", pred_b); end
    do_train(6'd0, 1'b1, 1'b0);
    n_cmp++; if (pred_b !== 1'b1) begin n_fail++; $display("FAIL sat_lo_t2: got %0d want 1", pred_b); end
  endtask

  task automatic test_gshare();
    reset_dut();
    set_pc(32'h100);
    n_cmp++; if (idx_a !== 6'h00) begin n_fail++; $display("FAIL gs_idx0: got %0h want 0", idx_a); end
    do_train(6'h3F, 1'b1, 1'b0);
    do_train(6'h3F, 1'b1, 1'b0);
    set_pc(32'h10C);
    n_cmp++; if (idx_a !== 6'h00) begin n_fail++; $display("FAIL gs_alias: got %0h want 0", idx_a); end
    set_pc(32'h100);
    n_cmp++; if (idx_a !== 6'h03) begin n_fail++; $display("FAIL gs_hist: got %0h want 3", idx_a); end
    set_pc(32'hF0);
    n_cmp++; if (idx_a !== 6'h3F) begin n_fail++; $display("FAIL gs_idx3f: got %0h want 3f", idx_a); end
    n_cmp++; if (pred_a !== 1'b1) begin n_fail++; $display("FAIL gs_pred3f: got %0d want 1", pred_a); end
    set_pc(32'hFC);
    n_cmp++; if (pred_a !== 1'b0) begin n_fail++; $display("FAIL gs_pred3c: got %0d want 0", pred_a); end
  endtask

  task automatic test_stall();
    reset_dut();
    branch_E     = 1'b1;
    stall_E      = 1'b1;
    branch_h_E   = 1'b1;
    predict_en_E = 1'b0;
    pht_idx_E    = 6'd0;
    step(); step(); step();
    n_cmp++; if (br_a !== 32'd0) begin n_fail++; $display("FAIL stall_br: got %0d want 0", br_a); end
    branch_E = 1'b0;
    stall_E  = 1'b0;
    step();
    n_cmp++; if (br_a !== 32'd0) begin n_fail++; $display("FAIL bubble_br: got %0d want 0", br_a); end
    branch_E = 1'b1;
    step();
    branch_E   = 1'b0;
    branch_h_E = 1'b0;
    n_cmp++; if (br_a !== 32'd1) begin n_fail++; $display("FAIL unstall_br: got %0d want 1", br_a); end
    n_cmp++; if (mis_a !== 32'd1) begin n_fail++; $display("FAIL unstall_mis: got %0d want 1", mis_a); end
    set_pc(32'h104);
    n_cmp++; if (idx_a !== 6'd0) begin n_fail++; $display("FAIL unstall_ghr: got %0h want 0", idx_a); end
    n_cmp++; if (pred_a !== 1'b1) begin n_fail++; $display("FAIL unstall_pred_a: got %0d want 1", pred_a); end
    set_pc(32'h100);
    n_cmp++; if (pred_b !== 1'b1) begin n_fail++; $display("FAIL unstall_pred_b: got %0d want 1", pred_b); end
  endtask

  task automatic test_same_cycle();
    reset_dut();
    pc_D         = 32'h100;
    branch_D     = 1'b1;
    branch_E     = 1'b1;
    stall_E      = 1'b0;
    branch_h_E   = 1'b1;
    predict_en_E = 1'b0;
    pht_idx_E    = 6'd0;
    #1;
    n_cmp++; if (pred_b !== 1'b0) begin n_fail++; $display("FAIL rw_same: got %0d want 0", pred_b); end
    n_cmp++; if (idx_a !== 6'd0) begin n_fail++; $display("FAIL rw_old_ghr: got %0h want 0", idx_a); end
    step();
    branch_E   = 1'b0;
    branch_h_E = 1'b0;
    n_cmp++; if (pred_b !== 1'b1) begin n_fail++; $display("FAIL rw_next: got %0d want 1", pred_b); end
    n_cmp++; if (idx_a !== 6'd1) begin n_fail++; $display("FAIL rw_new_ghr: got %0h want 1", idx_a); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] h_vec;
    logic [9:0] p_vec;
    h_vec = 10'b1101011100;
    p_vec = 10'b0100010101;
    reset_dut();
    for (int i = 0; i < 10; i++) do_train(6'(i), h_vec[i], p_vec[i]);
    n_cmp++; if (br_a !== 32'd10) begin n_fail++; $display("FAIL b2b_br: got %0d want 10", br_a); end
    n_cmp++; if (mis_a !== 32'd4) begin n_fail++; $display("FAIL b2b_mis: got %0d want 4", mis_a); end
    n_cmp++; if (mis_b !== 4'd4) begin n_fail++; $display("FAIL b2b_mis_b: got %0d want 4", mis_b); end
    reset_dut();
    for (int i = 0; i < 17; i++) do_train(6'd0, 1'b1, 1'b1);
    n_cmp++; if (br_b !== 4'd1) begin n_fail++; $display("FAIL wrap_br_b: got %0d want 1", br_b); end
    n_cmp++; if (br_a !== 32'd17) begin n_fail++; $display("FAIL wrap_br_a: got %0d want 17", br_a); end
    n_cmp++; if (mis_b !== 4'd0) begin n_fail++; $display("FAIL wrap_mis_b: got %0d want 0", mis_b); end
  endtask

  initial begin
    n_cmp        = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    pc_D         = 32'h0;
    branch_D     = 1'b0;
    branch_E     = 1'b0;
    branch_h_E   = 1'b0;
    predict_en_E = 1'b0;
    pht_idx_E    = 6'd0;
    stall_E      = 1'b0;
    #12;
    rst_n = 1'b1;
    step();
    test_reset();
    test_saturation();
    test_gshare();
    test_stall();
    test_same_cycle();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
